dice_roll_controller: RTL

Sequencing controller between the six die-select push buttons and the shared random-number source. It conditions and edge-detects each button and queues presses, serving one at a time in fixed priority order. For each roll it steps the RNG for a tumble period, then reduces the sample to a face value 1..N for the selected die and presents the result to the display logic. `switchTest` forces a deterministic maximum-face result for board bring-up.

---
 rtl/dice_roll_controller.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dice_roll_controller.sv
// dice_roll_controller
//
// Sequences die rolls between six die-select push buttons and a shared random
// number source. Each button is synchronized, debounced and edge-detected into
// a pending bit. Pending requests are served one at a time, with D4 at the
// highest priority. A roll steps the RNG for a tumble period, samples it, and
// reduces the sample to a face value 1..N by repeated subtraction. A test
// switch replaces the roll with a fixed maximum-face result.
//
// Ports:
//   clk                 system clock, all logic on the rising edge
//   reset_n             synchronous active-low reset
//   buttonD4..buttonD20 raw asynchronous button levels, 1 = pressed
//   switchTest          raw test-mode switch, 1 = force maximum face
//   rng_data[7:0]       current RNG output
//   rng_step            advance the RNG this cycle (TUMBLE only)
//   roll_value[4:0]     last result, 1..20
//   die_sel[2:0]        die of last result: 0=D4 1=D6 2=D8 3=D10 4=D12 5=D20
//   roll_valid          one-cycle pulse while a new result is presented
//   busy                high whenever the controller is not idle
module dice_roll_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TUMBLE_CYCLES   = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       buttonD4,
  input  logic       buttonD6,
  input  logic       buttonD8,
  input  logic       buttonD10,
  input  logic       buttonD12,
  input  logic       buttonD20,
  input  logic       switchTest,
  input  logic [7:0] rng_data,
  output logic       rng_step,
  output logic [4:0] roll_value,
  output logic [2:0] die_sel,
  output logic       roll_valid,
  output logic       busy
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TU_W = $clog2(TUMBLE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [TU_W-1:0] TU_LAST = TU_W'(TUMBLE_CYCLES - 1);
  localparam logic [TU_W-1:0] TU_ONE  = TU_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    TUMBLE,
    REDUCE,
    DONE
  } state_t;

  // Number of faces for each die index.
  function automatic logic [7:0] sides_of(input logic [2:0] die);
    case (die)
      3'd0:    sides_of = 8'd4;
      3'd1:    sides_of = 8'd6;
      3'd2:    sides_of = 8'd8;
      3'd3:    sides_of = 8'd10;
      3'd4:    sides_of = 8'd12;
      default: sides_of = 8'd20;
    endcase
  endfunction

  logic [5:0]      raw_buttons;
  logic [5:0]      btn_meta;
  logic [5:0]      btn_sync;
  logic            test_meta;
  logic            test_sync;
  logic [5:0]      accepted;
  logic [DB_W-1:0] db_cnt [6];
  logic [5:0]      accept_now;
  logic [5:0]      rise;
  logic [5:0]      pending;
  logic [5:0]      grant;
  logic [2:0]      winner;
  logic            any_pending;

  state_t          state;
  state_t          next_state;
  logic [2:0]      die_q;
  logic [TU_W-1:0] tumble_cnt;
  logic [7:0]      work;
  logic [7:0]      sides_cur;

  // Bit 0 is D4 so that the lowest index is also the highest priority.
  assign raw_buttons = {buttonD20, buttonD12, buttonD10, buttonD8, buttonD6, buttonD4};
  assign sides_cur   = sides_of(die_q);

  // A level is accepted on the DEBOUNCE_CYCLES-th consecutive differing
  // sample; a rising acceptance is the press event that sets a pending bit.
  always_comb begin
    accept_now = '0;
    rise       = '0;
    for (int i = 0; i < 6; i++) begin
      accept_now[i] = (btn_sync[i] != accepted[i]) && (db_cnt[i] == DB_LAST);
      rise[i]       = accept_now[i] && btn_sync[i];
    end
  end

  // Two-flop synchronizers and per-button debounce counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      btn_meta  <= '0;
      btn_sync  <= '0;
      test_meta <= 1'b0;
      test_sync <= 1'b0;
      accepted  <= '0;
      for (int i = 0; i < 6; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      btn_meta  <= raw_buttons;
      btn_sync  <= btn_meta;
      test_meta <= switchTest;
      test_sync <= test_meta;
      for (int i = 0; i < 6; i++) begin
        if (btn_sync[i] == accepted[i]) begin
          db_cnt[i] <= '0;
        end else if (accept_now[i]) begin
          accepted[i] <= btn_sync[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_ONE;
        end
      end
    end
  end

  // Fixed-priority pick of the lowest pending index; the grant mask clears
  // the winner's pending bit only when IDLE actually takes it.
  always_comb begin
    winner      = 3'd0;
    any_pending = |pending;
    grant       = '0;
    for (int i = 5; i >= 0; i--) begin
      if (pending[i]) begin
        winner = 3'(i);
      end
    end
    if ((state == IDLE) && any_pending) begin
      grant[winner] = 1'b1;
    end
  end

  // Set wins over clear so a press landing in the grant cycle is kept.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~grant) | rise;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the state-decoded outputs.
  always_comb begin
    next_state = state;
    rng_step   = 1'b0;
    roll_valid = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (any_pending) begin
          next_state = test_sync ? DONE : TUMBLE;
        end
      end
      TUMBLE: begin
        rng_step = 1'b1;
        if (tumble_cnt == TU_LAST) begin
          next_state = REDUCE;
        end
      end
      REDUCE: begin
        if (work < sides_cur) begin
          next_state = DONE;
        end
      end
      DONE: begin
        roll_valid = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Roll datapath. The result and die are loaded on the way into DONE so they
  // are already on the outputs during the roll_valid cycle, and an aborted
  // roll never touches them.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      die_q      <= '0;
      tumble_cnt <= '0;
      work       <= '0;
      roll_value <= '0;
      die_sel    <= '0;
    end else begin
      case (state)
        IDLE: begin
          tumble_cnt <= '0;
          if (any_pending) begin
            die_q <= winner;
            if (test_sync) begin
              roll_value <= 5'(sides_of(winner));
              die_sel    <= winner;
            end
          end
        end
        TUMBLE: begin
          tumble_cnt <= tumble_cnt + TU_ONE;
          if (tumble_cnt == TU_LAST) begin
            work <= rng_data;
          end
        end
        REDUCE: begin
          if (work >= sides_cur) begin
            work <= work - sides_cur;
          end else begin
            roll_value <= 5'(work + 8'd1);
            die_sel    <= die_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
